// File: rtl/ipv4_decode_pkg.sv
// Shared types and helpers for the IPv4/TCP receive path: decoder state
// encoding and the 16-bit ones' complement adder used by both checksums.
package ipv4_decode_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        PAYLOAD = 3'd2,
        DROP    = 3'd3,
        DONE    = 3'd4
    } ipv4_state_e;

    // End-around-carry add; a single fold is enough since a+b <= 17'h1FFFE.
    function automatic logic [15:0] ones_comp(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// Byte-serial ones' complement checksum accumulator. sum_o already includes
// the byte presented this cycle, so a verdict can be taken on the last byte.
module ip_csum_acc
    import ipv4_decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] sum_o
);

    logic [15:0] sum_q, sum_d;
    logic [7:0]  hi_q, hi_d;
    logic        odd_q, odd_d;
    logic [15:0] base_sum;
    logic        base_odd;

    always_comb begin
        base_sum = clear_i ? 16'd0 : sum_q;
        base_odd = clear_i ? 1'b0 : odd_q;
        sum_d    = base_sum;
        odd_d    = base_odd;
        hi_d     = hi_q;
        if (byte_valid_i) begin
            if (!base_odd) begin
                hi_d  = byte_i;
                odd_d = 1'b1;
            end else begin
                sum_d = ones_comp(base_sum, {hi_q, byte_i});
                odd_d = 1'b0;
            end
        end
    end

    assign sum_o = sum_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 16'd0;
            hi_q  <= 8'd0;
            odd_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            hi_q  <= hi_d;
            odd_q <= odd_d;
        end
    end

endmodule

// File: rtl/ipv4_decode.sv
// IPv4 receive header decoder: parses and checks the header, forwards the
// payload of accepted datagrams and reports a per-frame verdict.
//
// state   | meaning
// IDLE    | between frames; first valid byte is header byte 0
// HEADER  | collecting header bytes 1 .. 4*IHL-1
// PAYLOAD | forwarding bytes 4*IHL .. TotalLength-1
// DROP    | discarding bytes until valid falls (also the post-reset wait)
// DONE    | one-cycle end-of-frame, done pulse
module ipv4_decode
    import ipv4_decode_pkg::*;
#(
    parameter logic [31:0] LOCAL_IP = 32'hC0A8_00C7,
    parameter logic [7:0]  PROTO    = 8'd6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [7:0]  din,
    output logic [31:0] ip_sa,
    output logic [31:0] ip_da,
    output logic [7:0]  ip_ihl,
    output logic [15:0] ip_payload_size,
    output logic [7:0]  protocol,
    output logic        payload_valid,
    output logic [7:0]  payload_data,
    output logic        err,
    output logic        done
);

    ipv4_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  ver_q, ver_d;
    logic [7:0]  ihl_q, ihl_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  proto_q, proto_d;
    logic [31:0] sa_q, sa_d;
    logic [31:0] da_q, da_d;
    logic        bad_q, bad_d;
    logic        orphan_q, orphan_d;
    logic        pv_q, pv_d;
    logic [7:0]  pd_q, pd_d;
    logic        err_q, err_d;
    logic        done_q, done_d;

    logic [15:0] csum_sum;
    logic [15:0] hdr_bytes, hdr_last;
    logic [31:0] da_now;
    logic        hdr_bad, hdr_filtered;

    ip_csum_acc u_csum (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (state_q != HEADER),
        .byte_valid_i (valid && (state_q == IDLE || state_q == HEADER)),
        .byte_i       (din),
        .sum_o        (csum_sum)
    );

    // A too-short IHL still runs to byte 19 so every fixed field is seen.
    assign hdr_bytes    = {10'd0, ihl_q[3:0], 2'b00};
    assign hdr_last     = (ihl_q < 8'd5) ? 16'd19 : hdr_bytes - 16'd1;
    assign da_now       = (cnt_q == 16'd19) ? {da_q[23:0], din} : da_q;
    assign hdr_bad      = (csum_sum != 16'hFFFF) || (ver_q != 4'd4) ||
                          (ihl_q < 8'd5) || (len_q < hdr_bytes);
    assign hdr_filtered = (proto_q != PROTO) || (da_now != LOCAL_IP);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ver_d    = ver_q;
        ihl_d    = ihl_q;
        len_d    = len_q;
        proto_d  = proto_q;
        sa_d     = sa_q;
        da_d     = da_q;
        bad_d    = bad_q;
        orphan_d = orphan_q;
        pv_d     = 1'b0;
        pd_d     = pd_q;
        err_d    = err_q;
        done_d   = 1'b0;

        if (valid && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (valid) begin
                    state_d = HEADER;
                    cnt_d   = 16'd1;
                    ver_d   = din[7:4];
                    ihl_d   = {4'd0, din[3:0]};
                    err_d   = 1'b0;
                    bad_d   = 1'b0;
                end
            end
            HEADER: begin
                if (!valid) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    case (cnt_q)
                        16'd2:                      len_d   = {din, len_q[7:0]};
                        16'd3:                      len_d   = {len_q[15:8], din};
                        16'd9:                      proto_d = din;
                        16'd12, 16'd13, 16'd14, 16'd15: sa_d = {sa_q[23:0], din};
                        16'd16, 16'd17, 16'd18, 16'd19: da_d = {da_q[23:0], din};
                        default: ;
                    endcase
                    if (cnt_q == hdr_last) begin
                        if (hdr_bad) begin
                            bad_d   = 1'b1;
                            state_d = DROP;
                        end else if (hdr_filtered || len_q == hdr_bytes) begin
                            state_d = DROP;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (!valid) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    pv_d = 1'b1;
                    pd_d = din;
                    if (cnt_q == len_q - 16'd1) begin
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                if (!valid) begin
                    // Leftover of a frame cut by reset: resync silently.
                    if (orphan_q) begin
                        state_d  = IDLE;
                        cnt_d    = 16'd0;
                        orphan_d = 1'b0;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = bad_q || (cnt_q < len_q);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
            default: begin
                state_d = DROP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= DROP;
            cnt_q    <= 16'd0;
            ver_q    <= 4'd0;
            ihl_q    <= 8'd0;
            len_q    <= 16'd0;
            proto_q  <= 8'd0;
            sa_q     <= 32'd0;
            da_q     <= 32'd0;
            bad_q    <= 1'b0;
            orphan_q <= 1'b1;
            pv_q     <= 1'b0;
            pd_q     <= 8'd0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ver_q    <= ver_d;
            ihl_q    <= ihl_d;
            len_q    <= len_d;
            proto_q  <= proto_d;
            sa_q     <= sa_d;
            da_q     <= da_d;
            bad_q    <= bad_d;
            orphan_q <= orphan_d;
            pv_q     <= pv_d;
            pd_q     <= pd_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign ip_sa           = sa_q;
    assign ip_da           = da_q;
    assign ip_ihl          = ihl_q;
    assign ip_payload_size = len_q;
    assign protocol        = proto_q;
    assign payload_valid   = pv_q;
    assign payload_data    = pd_q;
    assign err             = err_q;
    assign done            = done_q;

endmodule

// File: tb/tb_ipv4_decode.sv
// Directed bench for ipv4_decode: expected payload bytes go into a queue as
// frames are driven and are popped as the decoder forwards them.
module tb_ipv4_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  din = 8'd0;
    logic [31:0] ip_sa, ip_da;
    logic [7:0]  ip_ihl, protocol, payload_data;
    logic [15:0] ip_payload_size;
    logic        payload_valid, err, done;

    int          n_checks = 0;
    int          n_fail = 0;
    int          pv_count = 0;
    int          done_count = 0;
    logic        err_at_done = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  frm[$];

    always #5 clk = ~clk;

    ipv4_decode dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid           (valid),
        .din             (din),
        .ip_sa           (ip_sa),
        .ip_da           (ip_da),
        .ip_ihl          (ip_ihl),
        .ip_payload_size (ip_payload_size),
        .protocol        (protocol),
        .payload_valid   (payload_valid),
        .payload_data    (payload_data),
        .err             (err),
        .done            (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (payload_valid === 1'b1) begin
            pv_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL payload_extra: observed byte %0h expected no payload", payload_data);
            end else begin
                check("payload_data", 32'(payload_data), 32'(exp_q.pop_front()));
            end
        end
        if (done === 1'b1) begin
            done_count++;
            err_at_done = err;
        end
    end

    // Reference header checksum over the 20-byte header in frm.
    function automatic logic [15:0] hdr_csum();
        logic [31:0] acc;
        acc = 32'd0;
        for (int i = 0; i < 10; i++) begin
            if (i != 5) acc += {16'd0, frm[2*i], frm[2*i+1]};
        end
        while (acc[31:16] != 16'd0) acc = {16'd0, acc[15:0]} + {16'd0, acc[31:16]};
        return ~acc[15:0];
    endfunction

    task automatic build(input logic [7:0] proto, input logic [15:0] tot_len, input int npay,
                         input int npad, input logic use_csum, input logic [15:0] csum_val);
        logic [15:0] c;
        frm.delete();
        frm = '{8'h45, 8'h00, tot_len[15:8], tot_len[7:0], 8'h00, 8'h00, 8'h40, 8'h00,
                8'h40, proto, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01,
                8'hC0, 8'hA8, 8'h00, 8'hC7};
        c = use_csum ? csum_val : hdr_csum();
        frm[10] = c[15:8];
        frm[11] = c[7:0];
        for (int k = 0; k < npay; k++) frm.push_back(8'(k * 7 + 3));
        for (int k = 0; k < npad; k++) frm.push_back(8'h00);
    endtask

    task automatic drive(input int from, input int upto, input logic fwd);
        int tot;
        tot = int'({frm[2], frm[3]});
        for (int i = from; i < upto; i++) begin
            @(posedge clk);
            #1;
            valid = 1'b1;
            din   = frm[i];
            if (fwd && i >= 20 && i < tot) exp_q.push_back(frm[i]);
        end
    endtask

    task automatic finish_frame();
        @(posedge clk);
        #1;
        valid = 1'b0;
        din   = 8'd0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        pv_count    = 0;
        done_count  = 0;
        err_at_done = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int exp_pv, input logic exp_err,
                               input int exp_done, input logic [7:0] exp_proto,
                               input logic [15:0] exp_len);
        check({tag, "_pv_cycles"}, 32'(pv_count), 32'(exp_pv));
        check({tag, "_done_pulses"}, 32'(done_count), 32'(exp_done));
        check({tag, "_err_at_done"}, 32'(err_at_done), 32'(exp_err));
        check({tag, "_err_held"}, 32'(err), 32'(exp_err));
        check({tag, "_ip_sa"}, ip_sa, 32'hC0A8_0001);
        check({tag, "_ip_da"}, ip_da, 32'hC0A8_00C7);
        check({tag, "_ip_ihl"}, 32'(ip_ihl), 32'd5);
        check({tag, "_len"}, 32'(ip_payload_size), 32'(exp_len));
        check({tag, "_protocol"}, 32'(protocol), 32'(exp_proto));
        check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ip_sa", ip_sa, 32'd0);
        check("rst_ip_da", ip_da, 32'd0);
        check("rst_ip_ihl", 32'(ip_ihl), 32'd0);
        check("rst_len", 32'(ip_payload_size), 32'd0);
        check("rst_protocol", 32'(protocol), 32'd0);
        check("rst_payload_valid", 32'(payload_valid), 32'd0);
        check("rst_payload_data", 32'(payload_data), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Good TCP frame: 20 payload bytes then 6 pad bytes
        start_frame();
        build(8'h06, 16'd40, 20, 6, 1'b1, 16'hB8B7);
        drive(0, frm.size(), 1'b1);
        finish_frame();
        check_frame("good", 20, 1'b0, 1, 8'h06, 16'd40);

        // Corrupted checksum
        start_frame();
        build(8'h06, 16'd40, 20, 6, 1'b1, 16'hB8B6);
        drive(0, frm.size(), 1'b0);
        finish_frame();
        check_frame("badcsum", 0, 1'b1, 1, 8'h06, 16'd40);

        // UDP protocol with a header checksum recomputed to stay valid: filtered silently
        start_frame();
        build(8'h11, 16'd40, 20, 6, 1'b0, 16'h0000);
        drive(0, frm.size(), 1'b0);
        finish_frame();
        check_frame("udp", 0, 1'b0, 1, 8'h11, 16'd40);

        // Header-only datagram (Total Length == 4*IHL) followed by padding
        start_frame();
        build(8'h06, 16'd20, 0, 6, 1'b0, 16'h0000);
        drive(0, frm.size(), 1'b0);
        finish_frame();
        check_frame("hdronly", 0, 1'b0, 1, 8'h06, 16'd20);

        // Valid falls after payload byte 10 of 20
        start_frame();
        build(8'h06, 16'd40, 20, 6, 1'b1, 16'hB8B7);
        drive(0, 30, 1'b1);
        finish_frame();
        check_frame("trunc", 10, 1'b1, 1, 8'h06, 16'd40);

        // Reset asserted during header byte 8, released with valid still high
        start_frame();
        build(8'h06, 16'd40, 20, 6, 1'b1, 16'hB8B7);
        drive(0, 9, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_payload_valid", 32'(payload_valid), 32'd0);
        check("midrst_ip_sa", ip_sa, 32'd0);
        check("midrst_ip_ihl", 32'(ip_ihl), 32'd0);
        check("midrst_len", 32'(ip_payload_size), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        drive(9, 12, 1'b0);
        rst_n = 1'b1;
        drive(12, frm.size(), 1'b0);
        finish_frame();
        check("orphan_pv_cycles", 32'(pv_count), 32'd0);
        check("orphan_done_pulses", 32'(done_count), 32'd0);
        check("orphan_ip_sa", ip_sa, 32'd0);
        check("orphan_ip_da", ip_da, 32'd0);
        check("orphan_ip_ihl", 32'(ip_ihl), 32'd0);
        check("orphan_protocol", 32'(protocol), 32'd0);
        check("orphan_err", 32'(err), 32'd0);

        // Next full frame after the reset decodes normally
        start_frame();
        build(8'h06, 16'd40, 20, 6, 1'b1, 16'hB8B7);
        drive(0, frm.size(), 1'b1);
        finish_frame();
        check_frame("postrst", 20, 1'b0, 1, 8'h06, 16'd40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
